// File: rtl/ascii_arbiter_pkg.sv
// ascii_arbiter_pkg: shared types and constants for the ASCII display arbiter.
//   arb_state_t   : arbiter state (IDLE = no owner, LOCKED = a source owns the line)
//   ASCII_NEWLINE : byte that ends a line and releases the lock
//   idx_width()   : bit width of a requester index (at least 1)
package ascii_arbiter_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority.sv
// rr_priority: combinational round-robin pick.
//   val       : request vector
//   ptr       : index where the search starts (must be < p_num_reqs)
//   grant     : one-hot winner, all-zero when val is empty
//   grant_idx : encoded winner (0 when val is empty)
module rr_priority
    import ascii_arbiter_pkg::*;
#(
    parameter  int p_num_reqs = 2,
    localparam int OW         = idx_width(p_num_reqs)
) (
    input  logic [p_num_reqs-1:0] val,
    input  logic [OW-1:0]         ptr,
    output logic [p_num_reqs-1:0] grant,
    output logic [OW-1:0]         grant_idx
);

    // Two passes: first the indices at or above ptr, then the wrapped ones
    // below it. The first valid index found in that order wins.
    always_comb begin
        logic w_found;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (!w_found && val[i] && (i >= int'(ptr))) begin
                w_found   = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = OW'(i);
            end
        end
        for (int i = 0; i < p_num_reqs; i++) begin
            if (!w_found && val[i] && (i < int'(ptr))) begin
                w_found   = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = OW'(i);
            end
        end
    end

endmodule

// File: rtl/ascii_arbiter.sv
// ascii_arbiter: round-robin, line-locking arbiter in front of the character
// display's single ASCII write port. A source that writes a non-newline byte
// owns the display until it writes a newline or stays silent for p_timeout
// cycles.
//   clk_25M, rst     : clock, synchronous active-high reset
//   req_ascii/val    : byte and valid per requester
//   req_rdy          : combinational accept per requester
//   ascii/ascii_val  : registered byte to the display, one-cycle valid pulse
//   grant_id         : current or last owner index
//   busy             : a source currently holds the lock
module ascii_arbiter
    import ascii_arbiter_pkg::*;
#(
    parameter  int p_num_reqs = 2,
    parameter  int p_timeout  = 1024,
    localparam int OW         = idx_width(p_num_reqs)
) (
    input  logic                       clk_25M,
    input  logic                       rst,
    input  logic [p_num_reqs-1:0][7:0] req_ascii,
    input  logic [p_num_reqs-1:0]      req_val,
    output logic [p_num_reqs-1:0]      req_rdy,
    output logic [7:0]                 ascii,
    output logic                       ascii_val,
    output logic [OW-1:0]              grant_id,
    output logic                       busy
);

    localparam int             CNT_W    = $clog2(p_timeout + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_timeout - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t            r_state, w_next_state;
    logic [OW-1:0]         r_owner, r_ptr, w_win_idx, w_xfer_idx;
    logic [p_num_reqs-1:0] w_win_grant;
    logic [CNT_W-1:0]      r_idle_cnt;
    logic [7:0]            r_ascii, w_xfer_byte;
    logic                  r_ascii_val, w_xfer, w_xfer_nl, w_expire;

    // Explicit modulo-N increment so ptr never leaves 0..N-1.
    function automatic logic [OW-1:0] f_wrap_inc(input logic [OW-1:0] v);
        if (int'(v) == p_num_reqs - 1) return '0;
        return OW'(int'(v) + 1);
    endfunction

    rr_priority #(.p_num_reqs(p_num_reqs)) u_rr (
        .val       (req_val),
        .ptr       (r_ptr),
        .grant     (w_win_grant),
        .grant_idx (w_win_idx)
    );

    // req_rdy is exclusive, so at most one lane can transfer.
    assign w_xfer      = |(req_val & req_rdy);
    assign w_xfer_idx  = (r_state == IDLE) ? w_win_idx : r_owner;
    assign w_xfer_byte = req_ascii[w_xfer_idx];
    assign w_xfer_nl   = w_xfer && (w_xfer_byte == ASCII_NEWLINE);
    // An owner transfer in the expiry cycle wins over the timeout.
    assign w_expire    = (r_state == LOCKED) && !w_xfer && (r_idle_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk_25M) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_xfer && !w_xfer_nl) w_next_state = LOCKED;
            LOCKED:  if (w_xfer_nl || w_expire) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_rdy = '0;
        if (r_state == IDLE) req_rdy = w_win_grant;
        else                 req_rdy[r_owner] = 1'b1;
        busy = (r_state == LOCKED);
    end

    // Owner, round-robin pointer, idle counter and display register
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            r_owner     <= '0;
            r_ptr       <= '0;
            r_idle_cnt  <= '0;
            r_ascii     <= 8'h00;
            r_ascii_val <= 1'b0;
        end else begin
            r_ascii_val <= w_xfer;
            if (w_xfer) r_ascii <= w_xfer_byte;
            if (r_state == IDLE) begin
                if (w_xfer) begin
                    r_owner    <= w_win_idx;
                    r_idle_cnt <= '0;
                    if (w_xfer_nl) r_ptr <= f_wrap_inc(w_win_idx);
                end
            end else begin
                if (w_xfer) begin
                    r_idle_cnt <= '0;
                    if (w_xfer_nl) r_ptr <= f_wrap_inc(r_owner);
                end else if (w_expire) begin
                    r_idle_cnt <= '0;
                    r_ptr      <= f_wrap_inc(r_owner);
                end else if (r_idle_cnt != CNT_MAX) begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end
        end
    end

    assign ascii     = r_ascii;
    assign ascii_val = r_ascii_val;
    assign grant_id  = r_owner;

endmodule

// File: tb/tb_ascii_arbiter.sv
// tb_ascii_arbiter: scoreboard bench. Each scenario walks a table of cycles;
// accepted bytes are pushed when driven and popped when ascii_val shows them.
module tb_ascii_arbiter;

    typedef struct {
        logic       rst;
        logic [1:0] val;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [1:0] rdy;   // expected req_rdy for this cycle's inputs
        logic       busy;  // expected busy at the start of this cycle
    } step_t;

    typedef struct {
        logic [7:0] b;
        logic [1:0] id;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [1:0][7:0] r2_ascii;
    logic [1:0]      r2_val, rdy2;
    logic [7:0]      a2;
    logic            av2, gid2, busy2;
    logic [2:0][7:0] r3_ascii;
    logic [2:0]      r3_val, rdy3;
    logic [7:0]      a3;
    logic            av3, busy3;
    logic [1:0]      gid3;

    exp_t q[$];
    int   checks;
    int   failures;

    ascii_arbiter #(.p_num_reqs(2), .p_timeout(4)) dut2 (
        .clk_25M(clk), .rst(rst), .req_ascii(r2_ascii), .req_val(r2_val),
        .req_rdy(rdy2), .ascii(a2), .ascii_val(av2), .grant_id(gid2), .busy(busy2)
    );

    ascii_arbiter #(.p_num_reqs(3), .p_timeout(4)) dut3 (
        .clk_25M(clk), .rst(rst), .req_ascii(r3_ascii), .req_val(r3_val),
        .req_rdy(rdy3), .ascii(a3), .ascii_val(av3), .grant_id(gid3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; r2_val = '0; r2_ascii = '0; r3_val = '0; r3_ascii = '0;
        repeat (2) @(negedge clk);
        checks++; if (av2 !== 1'b0)  begin failures++; $display("FAIL reset_av2 got=%b want=0", av2); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2 got=%b want=0", busy2); end
        checks++; if (gid2 !== 1'b0)  begin failures++; $display("FAIL reset_gid2 got=%b want=0", gid2); end
        checks++; if (rdy2 !== 2'b00) begin failures++; $display("FAIL reset_rdy2 got=%b want=00", rdy2); end
        checks++; if (a2 !== 8'h00)   begin failures++; $display("FAIL reset_ascii2 got=%h want=00", a2); end
        checks++; if (av3 !== 1'b0 || busy3 !== 1'b0 || gid3 !== 2'd0 || rdy3 !== 3'b000)
            begin failures++; $display("FAIL reset_dut3 got av=%b busy=%b gid=%0d rdy=%b want 0/0/0/000", av3, busy3, gid3, rdy3); end
    endtask

    task automatic test_line_lock();
        step_t s[$];
        exp_t  e;
        s.push_back('{1'b0, 2'b11, 8'h41, 8'h58, 2'b01, 1'b0});
        s.push_back('{1'b0, 2'b11, 8'h42, 8'h58, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b11, 8'h0A, 8'h58, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h58, 2'b10, 1'b0});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h0A, 2'b10, 1'b1});
        s.push_back('{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0});
        foreach (s[k]) begin
            @(negedge clk);
            checks++; if (av2 !== (q.size() != 0)) begin failures++; $display("FAIL lock_val step%0d got=%b want=%b", k, av2, q.size() != 0); end
            if (av2 === 1'b1 && q.size() != 0) begin
                e = q.pop_front();
                checks++; if (a2 !== e.b || gid2 !== e.id[0]) begin failures++; $display("FAIL lock_byte step%0d got=%h/%0d want=%h/%0d", k, a2, gid2, e.b, e.id); end
            end
            checks++; if (busy2 !== s[k].busy) begin failures++; $display("FAIL lock_busy step%0d got=%b want=%b", k, busy2, s[k].busy); end
            rst = s[k].rst; r2_val = s[k].val; r2_ascii[0] = s[k].a0; r2_ascii[1] = s[k].a1;
            #1;
            checks++; if (rdy2 !== s[k].rdy) begin failures++; $display("FAIL lock_rdy step%0d got=%b want=%b", k, rdy2, s[k].rdy); end
            if (!s[k].rst && (s[k].val & s[k].rdy) != 2'b00)
                q.push_back('{s[k].rdy[1] ? s[k].a1 : s[k].a0, {1'b0, s[k].rdy[1]}});
        end
    endtask

    task automatic test_round_robin();
        exp_t       e;
        logic [2:0] exp_rdy;
        for (int i = 0; i < 3; i++) r3_ascii[i] = 8'h0A;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++; if (av3 !== (q.size() != 0)) begin failures++; $display("FAIL rr_val step%0d got=%b want=%b", k, av3, q.size() != 0); end
            if (av3 === 1'b1 && q.size() != 0) begin
                e = q.pop_front();
                checks++; if (a3 !== e.b || gid3 !== e.id) begin failures++; $display("FAIL rr_grant step%0d got=%h/%0d want=%h/%0d", k, a3, gid3, e.b, e.id); end
            end
            checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL rr_busy step%0d got=%b want=0", k, busy3); end
            r3_val = (k < 6) ? 3'b111 : 3'b000;
            #1;
            exp_rdy = (k < 6) ? 3'(1 << (k % 3)) : 3'b000;
            checks++; if (rdy3 !== exp_rdy) begin failures++; $display("FAIL rr_rdy step%0d got=%b want=%b", k, rdy3, exp_rdy); end
            if (k < 6) q.push_back('{8'h0A, 2'(k % 3)});
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        exp_t  e;
        s.push_back('{1'b0, 2'b11, 8'h51, 8'h59, 2'b01, 1'b0});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b10, 1'b0});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h0A, 2'b10, 1'b1});
        s.push_back('{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0});
        foreach (s[k]) begin
            @(negedge clk);
            checks++; if (av2 !== (q.size() != 0)) begin failures++; $display("FAIL tmo_val step%0d got=%b want=%b", k, av2, q.size() != 0); end
            if (av2 === 1'b1 && q.size() != 0) begin
                e = q.pop_front();
                checks++; if (a2 !== e.b || gid2 !== e.id[0]) begin failures++; $display("FAIL tmo_byte step%0d got=%h/%0d want=%h/%0d", k, a2, gid2, e.b, e.id); end
            end
            checks++; if (busy2 !== s[k].busy) begin failures++; $display("FAIL tmo_busy step%0d got=%b want=%b", k, busy2, s[k].busy); end
            rst = s[k].rst; r2_val = s[k].val; r2_ascii[0] = s[k].a0; r2_ascii[1] = s[k].a1;
            #1;
            checks++; if (rdy2 !== s[k].rdy) begin failures++; $display("FAIL tmo_rdy step%0d got=%b want=%b", k, rdy2, s[k].rdy); end
            if (!s[k].rst && (s[k].val & s[k].rdy) != 2'b00)
                q.push_back('{s[k].rdy[1] ? s[k].a1 : s[k].a0, {1'b0, s[k].rdy[1]}});
        end
    endtask

    task automatic test_expiry_collision();
        step_t s[$];
        exp_t  e;
        s.push_back('{1'b0, 2'b11, 8'h51, 8'h59, 2'b01, 1'b0});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b11, 8'h52, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b10, 8'h00, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b11, 8'h0A, 8'h59, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0});
        foreach (s[k]) begin
            @(negedge clk);
            checks++; if (av2 !== (q.size() != 0)) begin failures++; $display("FAIL exp_val step%0d got=%b want=%b", k, av2, q.size() != 0); end
            if (av2 === 1'b1 && q.size() != 0) begin
                e = q.pop_front();
                checks++; if (a2 !== e.b || gid2 !== e.id[0]) begin failures++; $display("FAIL exp_byte step%0d got=%h/%0d want=%h/%0d", k, a2, gid2, e.b, e.id); end
            end
            checks++; if (busy2 !== s[k].busy) begin failures++; $display("FAIL exp_busy step%0d got=%b want=%b", k, busy2, s[k].busy); end
            rst = s[k].rst; r2_val = s[k].val; r2_ascii[0] = s[k].a0; r2_ascii[1] = s[k].a1;
            #1;
            checks++; if (rdy2 !== s[k].rdy) begin failures++; $display("FAIL exp_rdy step%0d got=%b want=%b", k, rdy2, s[k].rdy); end
            if (!s[k].rst && (s[k].val & s[k].rdy) != 2'b00)
                q.push_back('{s[k].rdy[1] ? s[k].a1 : s[k].a0, {1'b0, s[k].rdy[1]}});
        end
    endtask

    task automatic test_midlock_reset();
        step_t s[$];
        exp_t  e;
        s.push_back('{1'b0, 2'b11, 8'h61, 8'h4D, 2'b10, 1'b0});
        s.push_back('{1'b0, 2'b10, 8'h61, 8'h4E, 2'b10, 1'b1});
        s.push_back('{1'b1, 2'b11, 8'h61, 8'h4F, 2'b10, 1'b1});
        s.push_back('{1'b0, 2'b11, 8'h61, 8'h50, 2'b01, 1'b0});
        s.push_back('{1'b0, 2'b01, 8'h0A, 8'h00, 2'b01, 1'b1});
        s.push_back('{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0});
        foreach (s[k]) begin
            @(negedge clk);
            checks++; if (av2 !== (q.size() != 0)) begin failures++; $display("FAIL rst_val step%0d got=%b want=%b", k, av2, q.size() != 0); end
            if (av2 === 1'b1 && q.size() != 0) begin
                e = q.pop_front();
                checks++; if (a2 !== e.b || gid2 !== e.id[0]) begin failures++; $display("FAIL rst_byte step%0d got=%h/%0d want=%h/%0d", k, a2, gid2, e.b, e.id); end
            end
            checks++; if (busy2 !== s[k].busy) begin failures++; $display("FAIL rst_busy step%0d got=%b want=%b", k, busy2, s[k].busy); end
            rst = s[k].rst; r2_val = s[k].val; r2_ascii[0] = s[k].a0; r2_ascii[1] = s[k].a1;
            #1;
            checks++; if (rdy2 !== s[k].rdy) begin failures++; $display("FAIL rst_rdy step%0d got=%b want=%b", k, rdy2, s[k].rdy); end
            if (!s[k].rst && (s[k].val & s[k].rdy) != 2'b00)
                q.push_back('{s[k].rdy[1] ? s[k].a1 : s[k].a0, {1'b0, s[k].rdy[1]}});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_line_lock();
        test_round_robin();
        test_timeout();
        test_expiry_collision();
        test_midlock_reset();
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL scoreboard_drain left=%0d want=0", q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
